// File: rtl/posit_pkg.sv
// posit_pkg: shared constants and FSM state type for the posit<32,3> encoder.
// Holds format widths, special encodings and the encoder state enum.
package posit_pkg;

  localparam int N    = 32;
  localparam int ES   = 3;
  localparam int KMAX = N - 2;
  localparam int SW   = 10;
  localparam int MW   = 64;

  localparam logic [N-1:0] MAXPOS = 32'h7FFF_FFFF;
  localparam logic [N-1:0] MINPOS = 32'h0000_0001;
  localparam logic [N-1:0] NAR    = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE,
    REGIME,
    ROUND,
    OUTPUT
  } state_e;

endpackage

// File: rtl/posit_encoder_if.sv
// posit_encoder_if: request/result bundle of the posit encoder.
// master drives start + operand fields; slave returns posit_out, done, busy.
interface posit_encoder_if;
  import posit_pkg::*;

  logic          start;
  logic          sign_in;
  logic [SW-1:0] scale_in;
  logic [MW-1:0] mant_in;
  logic          zero_in;
  logic          nar_in;
  logic [N-1:0]  posit_out;
  logic          done;
  logic          busy;

  modport master (
    output start, sign_in, scale_in,
    output mant_in, zero_in, nar_in,
    input  posit_out, done, busy
  );

  modport slave (
    input  start, sign_in, scale_in,
    input  mant_in, zero_in, nar_in,
    output posit_out, done, busy
  );

endinterface

// File: rtl/posit_round.sv
// posit_round: round-to-nearest-even on a posit body, saturating at maxpos.
// Ports: body/guard/sticky in, rounded body out (purely combinational).
module posit_round #(
  parameter int BW = 31
) (
  input  logic [BW-1:0] body,
  input  logic          guard,
  input  logic          sticky,
  output logic [BW-1:0] rounded
);

  logic inc;
  logic sat;

  always_comb begin
    inc = guard & (body[0] | sticky);
    // all-ones body is maxpos; a carry would wrap to zero
    sat = &body;
    rounded = body;
    if (inc && !sat) begin
      rounded = body + {{(BW-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/posit_encoder.sv
// posit_encoder: sequential encoder from (sign, scale, mantissa) to posit<N,ES>.
// Ports: clk, rst (async, active-high), bus (slave: start/operands in, posit_out/done/busy out).
module posit_encoder #(
  parameter int N    = 32,
  parameter int ES   = 3,
  parameter int KMAX = 30
) (
  input  logic            clk,
  input  logic            rst,
  posit_encoder_if.slave  bus
);
  import posit_pkg::*;

  localparam int WW = ES + MW - 2 + N - 1;
  localparam logic signed [SW-1:0] KMAX_S = SW'(KMAX);
  localparam logic [4:0] RMAX = 5'(KMAX + 1);

  state_e        state_q, state_d;
  logic [WW-1:0] w_q, w_d;
  logic [4:0]    cnt_q, cnt_d;
  logic          term_q, term_d;
  logic          run_q, run_d;
  logic          neg_q, neg_d;
  logic [N-1:0]  res_q, res_d;
  logic [N-1:0]  posit_q, posit_d;
  logic          done_q, done_d;

  logic signed [SW-1:0] k;
  logic [4:0]    rlen;
  logic [4:0]    len;
  logic [WW-1:0] w_init;
  logic [N-2:0]  rounded;
  logic          unused_mant;

  // bits 63:62 are the fixed 01 prefix of a normalized mantissa
  assign unused_mant = ^bus.mant_in[MW-1:MW-2];

  assign k = $signed(bus.scale_in) >>> ES;

  // run length: k+1 for k>=0, -k for k<0 (~k+1 folds into the same add)
  assign rlen = (k[SW-1] ? ~k[4:0] : k[4:0]) + 5'd1;
  assign len  = (rlen == RMAX) ? RMAX : rlen + 5'd1;

  assign w_init = {bus.scale_in[ES-1:0],
                   bus.mant_in[MW-3:0],
                   {(N-1){1'b0}}};

  posit_round #(
    .BW(N-1)
  ) u_round (
    .body   (w_q[WW-1 -: N-1]),
    .guard  (w_q[WW-N]),
    .sticky (|w_q[WW-N-1:0]),
    .rounded(rounded)
  );

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    cnt_d   = cnt_q;
    term_d  = term_q;
    run_d   = run_q;
    neg_d   = neg_q;
    res_d   = res_q;
    posit_d = posit_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          w_d     = w_init;
          cnt_d   = len;
          term_d  = (rlen != RMAX);
          run_d   = ~k[SW-1];
          neg_d   = bus.sign_in;
          state_d = OUTPUT;
          if (bus.nar_in) begin
            res_d = NAR;
            neg_d = 1'b0;
          end else if (bus.zero_in) begin
            res_d = '0;
            neg_d = 1'b0;
          end else if (k > KMAX_S) begin
            res_d = MAXPOS;
          end else if (k < -KMAX_S) begin
            res_d = MINPOS;
          end else begin
            state_d = REGIME;
          end
        end
      end
      REGIME: begin
        // terminator goes in first so it lands below the run bits
        w_d    = {term_q ? ~run_q : run_q, w_q[WW-1:1]};
        term_d = 1'b0;
        cnt_d  = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        res_d   = {1'b0, rounded};
        state_d = OUTPUT;
      end
      OUTPUT: begin
        posit_d = neg_q ? (~res_q + 1'b1) : res_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      w_q     <= '0;
      cnt_q   <= '0;
      term_q  <= 1'b0;
      run_q   <= 1'b0;
      neg_q   <= 1'b0;
      res_q   <= '0;
      posit_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      cnt_q   <= cnt_d;
      term_q  <= term_d;
      run_q   <= run_d;
      neg_q   <= neg_d;
      res_q   <= res_d;
      posit_q <= posit_d;
      done_q  <= done_d;
    end
  end

  assign bus.posit_out = posit_q;
  assign bus.done      = done_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_posit_encoder.sv
// tb_posit_encoder: scoreboard bench for posit_encoder.
// Expected posits and latencies are queued at start and checked at done.
module tb_posit_encoder;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  logic [31:0] exp_q [$];
  int          lat_q [$];

  posit_encoder_if bus ();

  posit_encoder #(
    .N   (32),
    .ES  (3),
    .KMAX(30)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [63:0] M1 = 64'h4000_0000_0000_0000;

  task automatic send(input logic s, input logic [9:0] sc,
                      input logic [63:0] m, input logic z,
                      input logic na, input logic [31:0] ex,
                      input int lat);
    bus.sign_in  = s;
    bus.scale_in = sc;
    bus.mant_in  = m;
    bus.zero_in  = z;
    bus.nar_in   = na;
    bus.start    = 1'b1;
    exp_q.push_back(ex);
    lat_q.push_back(lat);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output bit ok);
    ok  = 1'b0;
    cyc = 0;
    while (!ok && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.done === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    int dn;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.sign_in = 1'b0;
    bus.scale_in = '0;
    bus.mant_in = M1;
    bus.zero_in = 1'b0;
    bus.nar_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (bus.posit_out !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_posit: got %h want 00000000", bus.posit_out);
    end
    n_tests++;
    if (bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_done: got %b want 0", bus.done);
    end
    n_tests++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy: got %b want 0", bus.busy);
    end
    rst = 1'b0;
    dn = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) dn++;
    end
    n_tests++;
    if (dn !== 0) begin
      n_fail++;
      $display("FAIL reset_idle_done: got %0d pulses want 0", dn);
    end
  endtask

  task automatic test_basic();
    string       nm  [6] = '{"one", "scale_m1", "neg_one",
                             "scale_8", "scale_m9", "neg_m9"};
    logic        s   [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [9:0]  sc  [6] = '{10'd0, 10'h3FF, 10'd0,
                             10'd8, 10'h3F7, 10'h3F7};
    logic [31:0] ex  [6] = '{32'h4000_0000, 32'h3C00_0000,
                             32'hC000_0000, 32'h6000_0000,
                             32'h1E00_0000, 32'hE200_0000};
    int          lat [6] = '{4, 4, 4, 5, 5, 5};
    int cyc;
    bit ok;
    logic [31:0] e;
    int el;
    for (int i = 0; i < 6; i++) begin
      send(s[i], sc[i], M1, 1'b0, 1'b0, ex[i], lat[i]);
      wait_done(cyc, ok);
      e  = exp_q.pop_front();
      el = lat_q.pop_front();
      n_tests++;
      if (!ok || bus.posit_out !== e) begin
        n_fail++;
        $display("FAIL %s value: got %h want %h done=%0d",
                 nm[i], bus.posit_out, e, ok);
      end
      n_tests++;
      if (cyc !== el) begin
        n_fail++;
        $display("FAIL %s latency: got %0d want %0d", nm[i], cyc, el);
      end
    end
  endtask

  task automatic test_rounding();
    string       nm [3] = '{"tie_even", "tie_odd", "sticky"};
    logic [63:0] m  [3] = '{64'h4000_0008_0000_0000,
                            64'h4000_0018_0000_0000,
                            64'h4000_0008_0000_0001};
    logic [31:0] ex [3] = '{32'h4000_0000, 32'h4000_0002,
                            32'h4000_0001};
    int cyc;
    bit ok;
    logic [31:0] e;
    int el;
    for (int i = 0; i < 3; i++) begin
      send(1'b0, 10'd0, m[i], 1'b0, 1'b0, ex[i], 4);
      wait_done(cyc, ok);
      e  = exp_q.pop_front();
      el = lat_q.pop_front();
      n_tests++;
      if (!ok || bus.posit_out !== e) begin
        n_fail++;
        $display("FAIL %s value: got %h want %h done=%0d",
                 nm[i], bus.posit_out, e, ok);
      end
      n_tests++;
      if (cyc !== el) begin
        n_fail++;
        $display("FAIL %s latency: got %0d want %0d", nm[i], cyc, el);
      end
    end
  endtask

  task automatic test_specials();
    string       nm [8] = '{"maxpos", "neg_maxpos", "minpos", "neg_minpos",
                            "nar", "zero_neg", "k31", "k_m31"};
    logic        s  [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [9:0]  sc [8] = '{10'd300, 10'd300, 10'h2D4, 10'h2D4,
                            10'd0, 10'd0, 10'd248, 10'h30F};
    logic        z  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        na [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] ex [8] = '{32'h7FFF_FFFF, 32'h8000_0001,
                            32'h0000_0001, 32'hFFFF_FFFF,
                            32'h8000_0000, 32'h0000_0000,
                            32'h7FFF_FFFF, 32'h0000_0001};
    int cyc;
    bit ok;
    logic [31:0] e;
    int el;
    for (int i = 0; i < 8; i++) begin
      send(s[i], sc[i], M1, z[i], na[i], ex[i], 1);
      wait_done(cyc, ok);
      e  = exp_q.pop_front();
      el = lat_q.pop_front();
      n_tests++;
      if (!ok || bus.posit_out !== e) begin
        n_fail++;
        $display("FAIL %s value: got %h want %h done=%0d",
                 nm[i], bus.posit_out, e, ok);
      end
      n_tests++;
      if (cyc !== el) begin
        n_fail++;
        $display("FAIL %s latency: got %0d want %0d", nm[i], cyc, el);
      end
    end
  endtask

  task automatic test_long_regime();
    string       nm  [7] = '{"k30_e0", "k30_e7_sat", "km30_e0",
                             "km30_round", "k29_e0", "k29_sticky",
                             "km29_e0"};
    logic [9:0]  sc  [7] = '{10'd240, 10'd247, 10'h310, 10'h317,
                             10'd232, 10'd236, 10'h318};
    logic [63:0] m   [7] = '{M1, M1, M1, M1, M1,
                             64'h4000_0000_0000_0001, M1};
    logic [31:0] ex  [7] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF,
                             32'h0000_0001, 32'h0000_0002,
                             32'h7FFF_FFFE, 32'h7FFF_FFFF,
                             32'h0000_0002};
    int          lat [7] = '{33, 33, 33, 33, 33, 33, 32};
    int cyc;
    bit ok;
    logic [31:0] e;
    int el;
    for (int i = 0; i < 7; i++) begin
      send(1'b0, sc[i], m[i], 1'b0, 1'b0, ex[i], lat[i]);
      wait_done(cyc, ok);
      e  = exp_q.pop_front();
      el = lat_q.pop_front();
      n_tests++;
      if (!ok || bus.posit_out !== e) begin
        n_fail++;
        $display("FAIL %s value: got %h want %h done=%0d",
                 nm[i], bus.posit_out, e, ok);
      end
      n_tests++;
      if (cyc !== el) begin
        n_fail++;
        $display("FAIL %s latency: got %0d want %0d", nm[i], cyc, el);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit ok;
    logic [31:0] e;
    int el;
    int bad;
    send(1'b0, 10'd8, M1, 1'b0, 1'b0, 32'h6000_0000, 5);
    wait_done(cyc, ok);
    e  = exp_q.pop_front();
    el = lat_q.pop_front();
    n_tests++;
    if (!ok || bus.posit_out !== e || cyc !== el) begin
      n_fail++;
      $display("FAIL b2b_first: got %h/%0d want %h/%0d",
               bus.posit_out, cyc, e, el);
    end
    send(1'b1, 10'd0, M1, 1'b0, 1'b1, 32'h8000_0000, 1);
    wait_done(cyc, ok);
    e  = exp_q.pop_front();
    el = lat_q.pop_front();
    n_tests++;
    if (!ok || bus.posit_out !== e || cyc !== el) begin
      n_fail++;
      $display("FAIL b2b_second: got %h/%0d want %h/%0d",
               bus.posit_out, cyc, e, el);
    end
    bad = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.done !== 1'b0 || bus.posit_out !== e) bad++;
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL hold: got %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_busy_ignore();
    int dones;
    logic [31:0] got;
    logic [31:0] e;
    send(1'b0, 10'd0, M1, 1'b0, 1'b0, 32'h4000_0000, 4);
    n_tests++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_high: got %b want 1", bus.busy);
    end
    bus.start    = 1'b1;
    bus.scale_in = 10'd300;
    dones = 0;
    got   = '0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        dones++;
        got = bus.posit_out;
      end
    end
    e = exp_q.pop_front();
    void'(lat_q.pop_front());
    n_tests++;
    if (dones !== 1) begin
      n_fail++;
      $display("FAIL busy_done_count: got %0d want 1", dones);
    end
    n_tests++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL busy_value: got %h want %h", got, e);
    end
  endtask

  task automatic test_reset_mid();
    int dn;
    int cyc;
    bit ok;
    logic [31:0] e;
    send(1'b0, 10'd8, M1, 1'b0, 1'b0, 32'h6000_0000, 5);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_tests++;
    if (bus.posit_out !== 32'h0 || bus.done !== 1'b0 ||
        bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got %h/%b/%b want 00000000/0/0",
               bus.posit_out, bus.done, bus.busy);
    end
    exp_q.delete();
    lat_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    dn = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) dn++;
    end
    n_tests++;
    if (dn !== 0) begin
      n_fail++;
      $display("FAIL mid_reset_no_done: got %0d pulses want 0", dn);
    end
    send(1'b0, 10'd0, M1, 1'b0, 1'b0, 32'h4000_0000, 4);
    wait_done(cyc, ok);
    e = exp_q.pop_front();
    void'(lat_q.pop_front());
    n_tests++;
    if (!ok || bus.posit_out !== e || cyc !== 4) begin
      n_fail++;
      $display("FAIL recover: got %h/%0d want %h/4",
               bus.posit_out, cyc, e);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_basic();
    test_rounding();
    test_specials();
    test_long_regime();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
